timer_host_seq: RTL
===================

# timer_host_seq

Hardware sequencer that acts as the Avalon-MM master for the team's 16-bit-data interval timer slave. It programs the period and control registers on command and services the timer interrupt by clearing status and counting ticks. On request it captures and reads back the 32-bit counter snapshot. It sits between fabric control logic, such as the camera frame pacer, and a timer instance, replacing the Nios software that would otherwise drive the timer.

## Interface
- `CONTINUOUS`, default 1: 1 = periodic mode, control word 0x0007; 0 = one-shot mode, control word 0x0005.
- `TICK_W`, default 16: width of the tick counter.
- `clk`  in  1  single clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `cmd_start`  in  1  one-cycle pulse that programs the timer and starts it.
- `cmd_period`  in  32  timer period value, sampled when `cmd_start` is accepted.
- `cmd_stop`  in  1  one-cycle pulse that stops the timer.
- `cmd_snap`  in  1  one-cycle pulse requesting a snapshot read.
- `tick`  out  1  one-cycle pulse per serviced timeout.
- `tick_count`  out  TICK_W  number of serviced timeouts since the last start.
- `snap_value`  out  32  last snapshot read from the timer.
- `snap_valid`  out  1  one-cycle pulse when `snap_value` updates.
- `busy`  out  1  high in every state except IDLE and RUN.
- `address`  out  3  timer register index.
- `chipselect`  out  1  bus cycle active.
- `write_n`  out  1  0 = write, 1 = read.
- `writedata`  out  16  write data.
- `readdata`  in  16  timer read data, registered by the slave.
- `irq`  in  1  timer interrupt, level, held until status is cleared.

## Operation
- Timer register map:
  - 0: status; any write clears the timeout.
  - 1: control; bit0 = ITO, bit1 = CONT, bit2 = START, bit3 = STOP.
  - 2 and 3: period low and period high.
  - 4 and 5: snapshot low and snapshot high; a write to either captures the counter.
- Every bus output is registered. Each state issues at most one bus cycle.
- States and transitions:
  - IDLE: `cmd_start` latches `cmd_period` and goes to WR_PL. `cmd_stop` and `cmd_snap` are ignored.
  - WR_PL: write address 2 with period[15:0], then WR_PH.
  - WR_PH: write address 3 with period[31:16], then WR_CTRL.
  - WR_CTRL: write address 1 with the mode control word, clear `tick_count`, then RUN.
  - RUN: event priority is `cmd_stop` > `cmd_start` > `irq` > `cmd_snap`.
    - `cmd_stop` goes to WR_STOP.
    - `cmd_start` restarts: latch the new period, then WR_PL.
    - `irq` goes to CLR_ST.
    - `cmd_snap` goes to SNAP_WR.
  - CLR_ST: write address 0 with 0x0000, pulse `tick`, increment `tick_count`. The counter wraps from all-ones to 0. Next state is RUN, or IDLE when CONTINUOUS=0.
  - WR_STOP: write address 1 with 0x0008, then IDLE.
  - SNAP_WR: write address 4 with 0x0000, then RD_L.
  - RD_L: read address 4, then RD_H.
  - RD_H: read address 5 and capture `readdata` as the low half, then RD_DONE.
  - RD_DONE: no bus cycle. Capture `readdata` as the high half, pulse `snap_valid`, then RUN.
- Command pulses that arrive while `busy` is high are dropped and never queued.
- `irq` is a level signal, so an `irq` that rises during a busy sequence is serviced on the first RUN cycle afterwards.
- In RUN with no event pending, and in IDLE, the bus is idle.

## Timing
- Bus write: a single cycle with `chipselect`=1 and `write_n`=0. There is no waitrequest.
- Bus read: a single cycle with `chipselect`=1 and `write_n`=1. The matching `readdata` is valid and sampled in the following cycle.
- Idle bus values: `chipselect`=0, `write_n`=1, `address`=0, `writedata`=0.
- Start latency: `cmd_start` in cycle 0 puts writes on the bus in cycles 1, 2 and 3. RUN is reached in cycle 4.
- Interrupt latency: `irq` high in RUN produces the status-clear write and the `tick` pulse one cycle later.
- Snapshot latency: `cmd_snap` accepted in cycle 0 produces `snap_valid` in cycle 4, with busy high in cycles 1–4.
- Reset: when `reset_n`=0 at a clock edge, the next state is IDLE. All outputs go to 0, except `write_n`=1. `tick_count`, `snap_value` and the latched period also clear. An in-flight sequence is abandoned and no bus cycle is issued in the reset cycle.

## Structure
- Shared package `timer_regs_pkg` holds:
  - register address constants;
  - control bit positions;
  - control word constants: 0x0007 (start, continuous), 0x0005 (start, one-shot), 0x0008 (stop);
  - the state enum.
- Single module with no sub-module. The read path is two states and does not justify a separate block.

## Test plan
- Start: `cmd_period`=0x0001C907 → bus writes (2, 0xC907), (3, 0x0001), (1, 0x0007) on consecutive cycles; `busy` high for 3 cycles.
- Tick service: three `irq` assertions in RUN → three writes (0, 0x0000), three `tick` pulses, `tick_count`=3. Preset `tick_count` to 0xFFFF, then one `irq` → `tick_count` wraps to 0.
- Snapshot: timer model returns 0x1234 for address 4 and 0x0009 for address 5 → `snap_value`=0x00091234 and `snap_valid` high exactly 4 cycles after `cmd_snap`.
- Collisions:
  - `irq` asserted during a snapshot read → status-clear write occurs in the first RUN cycle after RD_DONE.
  - `cmd_stop` and `irq` in the same cycle → write (1, 0x0008) only, then IDLE.
- One-shot, with CONTINUOUS=0: control write of 0x0005, then after the first `irq` the block clears status and returns to IDLE; `cmd_snap` in IDLE produces no bus activity.
- Reset during WR_PH → next cycle IDLE with all outputs at reset values; a fresh `cmd_start` then produces a complete, correct write sequence.

Source files
------------

// File: rtl/timer_regs_pkg.sv
// timer_regs_pkg: register map, control words and sequencer states for the interval timer host
package timer_regs_pkg;
  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PERL   = 3'd2;
  localparam logic [2:0] A_PERH   = 3'd3;
  localparam logic [2:0] A_SNAPL  = 3'd4;
  localparam logic [2:0] A_SNAPH  = 3'd5;
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;
  localparam logic [15:0] CTRL_GO_CONT = 16'h0007;
  localparam logic [15:0] CTRL_GO_ONCE = 16'h0005;
  localparam logic [15:0] CTRL_HALT    = 16'h0008;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_CLR_ST,
    S_WR_STOP, S_SNAP_WR, S_RD_L, S_RD_H, S_RD_DONE
  } state_t;
endpackage

// File: rtl/timer_host_seq.sv
// timer_host_seq: Avalon-MM master that programs, services and snapshots an interval timer
module timer_host_seq
  import timer_regs_pkg::*;
#(
  parameter bit CONTINUOUS = 1'b1,
  parameter int TICK_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_stop,
  input  logic              cmd_snap,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic              busy,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [15:0]       writedata,
  input  logic [15:0]       readdata,
  input  logic              irq
);
  state_t r_state, w_next;
  logic [31:0] r_period, w_period, r_snap;
  logic [15:0] r_snap_lo, w_wdata;
  logic [TICK_W-1:0] r_tick_count;
  logic [2:0] w_addr;
  logic w_cs, w_write_n;
  always_comb begin
    w_next = r_state;
    w_period = r_period;
    case (r_state)
      S_IDLE:    if (cmd_start) begin w_next = S_WR_PL; w_period = cmd_period; end
      S_WR_PL:   w_next = S_WR_PH;
      S_WR_PH:   w_next = S_WR_CTRL;
      S_WR_CTRL: w_next = S_RUN;
      S_RUN:
        if (cmd_stop) w_next = S_WR_STOP;
        else if (cmd_start) begin w_next = S_WR_PL; w_period = cmd_period; end
        else if (irq) w_next = S_CLR_ST;
        else if (cmd_snap) w_next = S_SNAP_WR;
      S_CLR_ST:  w_next = CONTINUOUS ? S_RUN : S_IDLE;
      S_WR_STOP: w_next = S_IDLE;
      S_SNAP_WR: w_next = S_RD_L;
      S_RD_L:    w_next = S_RD_H;
      S_RD_H:    w_next = S_RD_DONE;
      S_RD_DONE: w_next = S_RUN;
      default:   w_next = S_IDLE;
    endcase
  end
  // bus is decoded from the next state so the registered outputs line up with the state they belong to
  always_comb begin
    w_cs = 1'b1;
    w_write_n = 1'b0;
    w_addr = A_STATUS;
    w_wdata = 16'h0000;
    case (w_next)
      S_WR_PL:   begin w_addr = A_PERL; w_wdata = w_period[15:0]; end
      S_WR_PH:   begin w_addr = A_PERH; w_wdata = w_period[31:16]; end
      S_WR_CTRL: begin w_addr = A_CTRL; w_wdata = CONTINUOUS ? CTRL_GO_CONT : CTRL_GO_ONCE; end
      S_CLR_ST:  w_addr = A_STATUS;
      S_WR_STOP: begin w_addr = A_CTRL; w_wdata = CTRL_HALT; end
      S_SNAP_WR: w_addr = A_SNAPL;
      S_RD_L:    begin w_addr = A_SNAPL; w_write_n = 1'b1; end
      S_RD_H:    begin w_addr = A_SNAPH; w_write_n = 1'b1; end
      default:   begin w_cs = 1'b0; w_write_n = 1'b1; end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_period <= 32'h0;
      r_tick_count <= '0;
      r_snap_lo <= 16'h0;
      r_snap <= 32'h0;
      chipselect <= 1'b0;
      write_n <= 1'b1;
      address <= 3'd0;
      writedata <= 16'h0;
    end else begin
      r_state <= w_next;
      r_period <= w_period;
      chipselect <= w_cs;
      write_n <= w_write_n;
      address <= w_addr;
      writedata <= w_wdata;
      if (r_state == S_WR_CTRL) r_tick_count <= '0;
      else if (r_state == S_CLR_ST) r_tick_count <= r_tick_count + 1'b1;
      if (r_state == S_RD_H) r_snap_lo <= readdata;
      if (r_state == S_RD_DONE) r_snap <= {readdata, r_snap_lo};
    end
  end
  assign tick = r_state == S_CLR_ST;
  assign tick_count = r_tick_count;
  assign snap_valid = r_state == S_RD_DONE;
  assign snap_value = snap_valid ? {readdata, r_snap_lo} : r_snap;
  assign busy = !(r_state == S_IDLE || r_state == S_RUN);
endmodule
